add_sub_seq: RTL and testbench



---
 rtl/add_seq_pkg.sv | 25 ++
 rtl/add_sub_seq_if.sv | 28 ++
 rtl/digit_adder.sv | 16 +
 rtl/add_sub_seq.sv | 197 +++++++++++++++++++
 tb/tb_add_sub_seq.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_seq_pkg.sv
// Shared types for the digit-serial adder/subtractor.
//   op_e    : operation encoding carried on the request bus
//   state_e : control FSM states of add_sub_seq
package add_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MADD = 2'b10,
    OP_MSUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PASS1 = 2'b01,
    PASS2 = 2'b10,
    DONE  = 2'b11
  } state_e;

  // First pass computes a + ~b + 1 for both subtract flavours.
  function automatic logic is_sub_op(op_e op);
    return (op == OP_SUB) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/add_sub_seq_if.sv
// Request/response bus of add_sub_seq.
//   in_valid/in_ready   : operand handshake (op, a, b, m)
//   out_valid/out_ready : result handshake (result, cout)
// master drives requests and accepts results; slave is the arithmetic block.
interface add_sub_seq_if #(
  parameter int unsigned N = 256
);
  logic              in_valid;
  logic              in_ready;
  add_seq_pkg::op_e  op;
  logic [N-1:0]      a;
  logic [N-1:0]      b;
  logic [N-1:0]      m;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      result;
  logic              cout;

  modport master (
    output in_valid, op, a, b, m, out_ready,
    input  in_ready, out_valid, result, cout
  );

  modport slave (
    input  in_valid, op, a, b, m, out_ready,
    output in_ready, out_valid, result, cout
  );
endinterface

// File: rtl/digit_adder.sv
// Combinational W-bit adder: {cout_o, sum_o} = a_i + b_i + cin_i.
//   a_i, b_i : W-bit addends
//   cin_i    : carry in
//   sum_o    : W-bit sum
//   cout_o   : carry out
module digit_adder #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
endmodule

// File: rtl/add_sub_seq.sv
// Digit-serial N-bit adder/subtractor with optional modular correction.
// One W-bit carry chain processes the operands LSB digit first; modular ops
// take a second pass over the first-pass sum to apply the correction.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : request (in_valid/in_ready, op, a, b, m) and
//              response (out_valid/out_ready, result, cout)
module add_sub_seq
  import add_seq_pkg::*;
#(
  parameter int unsigned N = 256,
  parameter int unsigned W = 64
) (
  input logic          clk,
  input logic          rst,
  add_sub_seq_if.slave bus
);

  localparam int unsigned D    = N / W;
  localparam int unsigned CntW = (D > 1) ? $clog2(D) : 1;

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d, m_q, m_d;
  logic [N-1:0]   s_q, s_d, t_q, t_d;
  logic [N-1:0]   result_q, result_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic           c1_q, c1_d;
  logic           cout_q, cout_d;

  logic [W-1:0]   dig_a, dig_b, dig_sum;
  logic           dig_cin, dig_cout;
  logic           first_dig, last_dig, corr;
  logic [N-1:0]   dig_top, s_in, s_rot, t_in;

  assign first_dig = (cnt_q == '0);
  assign last_dig  = (cnt_q == CntW'(D - 1));

  // Operand muxes in front of the single shared carry chain.
  always_comb begin
    if (state_q == PASS2) begin
      dig_a   = s_q[W-1:0];
      dig_b   = (op_q == OP_MADD) ? ~m_q[W-1:0] : m_q[W-1:0];
      dig_cin = first_dig ? (op_q == OP_MADD) : carry_q;
    end else begin
      dig_a   = a_q[W-1:0];
      dig_b   = is_sub_op(op_q) ? ~b_q[W-1:0] : b_q[W-1:0];
      dig_cin = first_dig ? is_sub_op(op_q) : carry_q;
    end
  end

  digit_adder #(
    .W (W)
  ) u_digit_adder (
    .a_i    (dig_a),
    .b_i    (dig_b),
    .cin_i  (dig_cin),
    .sum_o  (dig_sum),
    .cout_o (dig_cout)
  );

  // New digit enters at the top; after D shifts the register is LSB-aligned.
  // Shifting by W == N yields zero, so D = 1 needs no special case.
  assign dig_top = N'(dig_sum) << (N - W);
  assign s_in    = (s_q >> W) | dig_top;
  assign t_in    = (t_q >> W) | dig_top;
  // s is rotated during PASS2 so it is intact again for the modadd select.
  assign s_rot   = (s_q >> W) | (N'(s_q[W-1:0]) << (N - W));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    s_d      = s_q;
    t_d      = t_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    c1_d     = c1_q;
    result_d = result_q;
    cout_d   = cout_q;
    corr     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          m_d     = bus.m;
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = PASS1;
        end
      end

      PASS1: begin
        a_d     = a_q >> W;
        b_d     = b_q >> W;
        s_d     = s_in;
        carry_d = dig_cout;
        cnt_d   = cnt_q + 1'b1;
        if (last_dig) begin
          cnt_d   = '0;
          carry_d = 1'b0;
          c1_d    = dig_cout;
          unique case (op_q)
            OP_ADD, OP_SUB: begin
              result_d = s_in;
              cout_d   = dig_cout;
              state_d  = DONE;
            end
            OP_MADD: state_d = PASS2;
            OP_MSUB: begin
              // Borrow means a < b: add m back in the second pass.
              if (!dig_cout) begin
                state_d = PASS2;
              end else begin
                result_d = s_in;
                cout_d   = 1'b0;
                state_d  = DONE;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end

      PASS2: begin
        s_d     = s_rot;
        m_d     = m_q >> W;
        t_d     = t_in;
        carry_d = dig_cout;
        cnt_d   = cnt_q + 1'b1;
        if (last_dig) begin
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = DONE;
          if (op_q == OP_MADD) begin
            // Subtract m when a + b overflowed N bits or landed at/above m.
            corr     = c1_q | dig_cout;
            result_d = corr ? t_in : s_rot;
            cout_d   = corr;
          end else begin
            result_d = t_in;
            cout_d   = 1'b1;
          end
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      s_q      <= '0;
      t_q      <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      c1_q     <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      s_q      <= s_d;
      t_q      <= t_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      c1_q     <= c1_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_add_sub_seq.sv
// Scoreboard bench for add_sub_seq: a D=4 instance (N=256, W=64) and a D=1
// instance (N=W=64).
module tb_add_sub_seq;
  import add_seq_pkg::*;

  typedef struct {
    logic [255:0] res;
    logic         cout;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  add_sub_seq_if #(.N(256)) bus ();
  add_sub_seq_if #(.N(64))  bus1 ();

  add_sub_seq #(.N(256), .W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  add_sub_seq #(.N(64), .W(64)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Waits for out_valid on the D=4 instance, then pops and compares.
  task automatic wait_result(input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 60);
    check_eq({tag, ".valid"}, bus.out_valid, 1'b1);
    check_eq({tag, ".sb"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq({tag, ".result"}, bus.result, e.res);
      check_eq({tag, ".cout"}, bus.cout, e.cout);
      check_eq({tag, ".latency"}, lat, e.lat);
    end
    if (bus.out_ready) begin
      @(posedge clk);
      #1;
      check_eq({tag, ".ready_after"}, bus.in_ready, 1'b1);
    end
  endtask

  task automatic run_op(input string tag, input op_e op, input logic [255:0] a,
                        input logic [255:0] b, input logic [255:0] m,
                        input logic [255:0] exp_res, input logic exp_cout, input int exp_lat);
    int guard;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.m        = m;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, ".in_ready"}, bus.in_ready, 1'b1);
    @(posedge clk);
    sb.push_back('{exp_res, exp_cout, exp_lat});
    #1 bus.in_valid = 1'b0;
    wait_result(tag);
  endtask

  task automatic run_op1(input string tag, input op_e op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] m,
                         input logic [63:0] exp_res, input logic exp_cout, input int exp_lat);
    int   lat;
    exp_t e;
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.op       = op;
    bus1.a        = a;
    bus1.b        = b;
    bus1.m        = m;
    check_eq({tag, ".in_ready"}, bus1.in_ready, 1'b1);
    @(posedge clk);
    sb.push_back('{256'(exp_res), exp_cout, exp_lat});
    #1 bus1.in_valid = 1'b0;
    lat = 0;
    do begin
      if (lat > 0 || !bus1.out_valid) begin
        @(posedge clk);
        #1;
      end
      lat++;
    end while (!bus1.out_valid && lat < 20);
    check_eq({tag, ".valid"}, bus1.out_valid, 1'b1);
    check_eq({tag, ".sb"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq({tag, ".result"}, 256'(bus1.result), e.res);
      check_eq({tag, ".cout"}, bus1.cout, e.cout);
      check_eq({tag, ".latency"}, lat, e.lat);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] p, a, b, r;
    logic [256:0] s;
    logic         c;
    logic [63:0]  m61, ones64;

    p      = (256'd1 << 255) - 256'd19;
    m61    = (64'd1 << 61) - 64'd1;
    ones64 = '1;

    bus.in_valid  = 1'b0;
    bus.op        = OP_ADD;
    bus.a         = '0;
    bus.b         = '0;
    bus.m         = '0;
    bus.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.op        = OP_ADD;
    bus1.a         = '0;
    bus1.b         = '0;
    bus1.m         = '0;
    bus1.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_eq("reset.in_ready", bus.in_ready, 1'b1);
    check_eq("reset.out_valid", bus.out_valid, 1'b0);
    check_eq("reset.result", bus.result, 256'd0);
    check_eq("reset.cout", bus.cout, 1'b0);
    rst = 1'b0;

    // Directed cases.
    run_op("add_wrap", OP_ADD, '1, 256'd1, p, 256'd0, 1'b1, 4);
    run_op("sub_neg", OP_SUB, 256'd5, 256'd7, p, ~256'd1, 1'b0, 4);
    run_op("sub_pos", OP_SUB, 256'd7, 256'd5, p, 256'd2, 1'b1, 4);
    run_op("madd_corr", OP_MADD, p - 256'd1, 256'd2, p, 256'd1, 1'b1, 8);
    run_op("madd_nocorr", OP_MADD, 256'd1, 256'd2, p, 256'd3, 1'b0, 8);
    run_op("msub_borrow", OP_MSUB, 256'd3, 256'd5, p, p - 256'd2, 1'b1, 8);
    run_op("msub_noborrow", OP_MSUB, 256'd5, 256'd3, p, 256'd2, 1'b0, 4);

    // Random plain add/sub against a wide-integer model.
    for (int i = 0; i < 4; i++) begin
      a = rand256();
      b = rand256();
      if (i % 2 == 0) begin
        s = {1'b0, a} + {1'b0, b};
        run_op("rnd_add", OP_ADD, a, b, p, s[255:0], s[256], 4);
      end else begin
        r = a - b;
        run_op("rnd_sub", OP_SUB, a, b, p, r, a >= b, 4);
      end
    end

    // Random modular ops with a, b < p.
    for (int i = 0; i < 4; i++) begin
      a = rand256() % p;
      b = rand256() % p;
      if (i % 2 == 0) begin
        s = {1'b0, a} + {1'b0, b};
        c = (s >= {1'b0, p});
        r = c ? (s[255:0] - p) : s[255:0];
        run_op("rnd_madd", OP_MADD, a, b, p, r, c, 8);
      end else begin
        c = (a < b);
        r = c ? (a - b + p) : (a - b);
        run_op("rnd_msub", OP_MSUB, a, b, p, r, c, c ? 8 : 4);
      end
    end

    // Backpressure: result held, new request ignored until released.
    bus.out_ready = 1'b0;
    run_op("bp_first", OP_ADD, 256'd10, 256'd20, p, 256'd30, 1'b0, 4);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = OP_ADD;
    bus.a        = 256'd100;
    bus.b        = 256'd200;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp.result", bus.result, 256'd30);
      check_eq("bp.cout", bus.cout, 1'b0);
      check_eq("bp.in_ready", bus.in_ready, 1'b0);
      check_eq("bp.out_valid", bus.out_valid, 1'b1);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp.release_ready", bus.in_ready, 1'b1);
    check_eq("bp.release_valid", bus.out_valid, 1'b0);
    @(posedge clk);
    sb.push_back('{256'd300, 1'b0, 4});
    #1;
    bus.in_valid = 1'b0;
    check_eq("bp.accepted", bus.in_ready, 1'b0);
    wait_result("bp_second");

    // Reset during PASS1 digit 2.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = OP_ADD;
    bus.a        = 256'd1;
    bus.b        = 256'd2;
    check_eq("rst.in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("rst.out_valid", bus.out_valid, 1'b0);
    check_eq("rst.in_ready_hi", bus.in_ready, 1'b1);
    check_eq("rst.result", bus.result, 256'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_eq("rst.no_output", bus.out_valid, 1'b0);
    end
    run_op("post_rst_add", OP_ADD, 256'd1, 256'd1, p, 256'd2, 1'b0, 4);

    // D = 1 instance.
    run_op1("d1_add_wrap", OP_ADD, ones64, 64'd1, m61, 64'd0, 1'b1, 1);
    run_op1("d1_madd", OP_MADD, m61 - 64'd1, 64'd2, m61, 64'd1, 1'b1, 2);
    run_op1("d1_msub", OP_MSUB, 64'd3, 64'd5, m61, m61 - 64'd2, 1'b1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
